buffer_uart_tx: RTL and testbench

- Downstream consumer of the sample FIFO. Drains one 9-bit word at a time over its valid/read handshake.
- Each word is serialised as two 8N1 UART frames on a single TX line toward the host PC.
- Sits between the buffer's output port and the FPGA UART pin. It is the only reader of the buffer.

---
 rtl/buffer_uart_tx_pkg.sv | 18 +
 rtl/buffer_uart_tx_byte.sv | 104 ++++++++++
 rtl/buffer_uart_tx.sv | 87 ++++++++
 tb/tb_buffer_uart_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/buffer_uart_tx_pkg.sv
// Shared types and framing constants for the buffer-to-host UART transmitter.
package buffer_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic FIRST_BYTE_MARK  = 1'b1;
  localparam logic SECOND_BYTE_MARK = 1'b0;
  localparam logic UART_IDLE        = 1'b1;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned CNT_W                = 16;

endpackage

// File: rtl/buffer_uart_tx_byte.sv
// Single 8N1 frame engine: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte
  import buffer_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       short_stop,
  output logic       tx,
  output logic       done_c
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST       = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST_SHORT = BAUD_W'(CLKS_PER_BIT - 2);

  tx_state_e         state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              tx_n;
  logic              bit_end;
  logic [BAUD_W-1:0] stop_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= UART_IDLE;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // A short stop lets the caller's idle cycle complete the final stop bit.
  always_comb begin
    state_n   = state;
    baud_n    = baud + BAUD_W'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    done_c    = 1'b0;
    bit_end   = (baud == BAUD_LAST);
    stop_last = short_stop ? BAUD_LAST_SHORT : BAUD_LAST;

    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = UART_IDLE;
        if (start) begin
          state_n = START;
          shreg_n = byte_in;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = UART_IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP: begin
        if (baud == stop_last) begin
          done_c = 1'b1;
          baud_n = '0;
          if (start) begin
            state_n = START;
            shreg_n = byte_in;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/buffer_uart_tx.sv
// Drains the sample buffer one word at a time and sends each word as two UART bytes.
module buffer_uart_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 9,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_read,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned LOW_W = DATA_WIDTH - 7;

  logic [LOW_W-1:0] low_q, low_q_n;
  logic             byte_idx, byte_idx_n;
  logic             busy_n;
  logic             data_read_n;
  logic [CNT_W-1:0] word_cnt_n;
  logic             accept;
  logic             start;
  logic             frame_done;
  logic [7:0]       byte_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      low_q     <= '0;
      byte_idx  <= 1'b0;
      busy      <= 1'b0;
      data_read <= 1'b0;
      word_cnt  <= '0;
    end else begin
      low_q     <= low_q_n;
      byte_idx  <= byte_idx_n;
      busy      <= busy_n;
      data_read <= data_read_n;
      word_cnt  <= word_cnt_n;
    end
  end

  // Byte 0 goes straight from data_in so tx falls on the accepting edge.
  always_comb begin
    low_q_n     = low_q;
    byte_idx_n  = byte_idx;
    busy_n      = busy;
    data_read_n = 1'b0;
    word_cnt_n  = word_cnt;
    accept      = !busy && data_in_valid;
    start       = 1'b0;
    byte_sel    = {SECOND_BYTE_MARK, 7'(low_q)};

    if (accept) begin
      start       = 1'b1;
      byte_sel    = {FIRST_BYTE_MARK, data_in[DATA_WIDTH-1 -: 7]};
      low_q_n     = data_in[LOW_W-1:0];
      byte_idx_n  = 1'b0;
      busy_n      = 1'b1;
      data_read_n = 1'b1;
    end else if (busy && frame_done) begin
      if (!byte_idx) begin
        start      = 1'b1;
        byte_idx_n = 1'b1;
      end else begin
        busy_n     = 1'b0;
        word_cnt_n = word_cnt + CNT_W'(1);
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_sel),
    .short_stop (byte_idx),
    .tx         (tx),
    .done_c     (frame_done)
  );

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Self-checking bench: buffer model feeding the transmitter, line decoded against a word-level model.
module tb_buffer_uart_tx;

  localparam int unsigned DW       = 9;
  localparam int unsigned CPB      = 4;
  localparam int unsigned WORD_CYC = 20 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_read;
  logic          tx;
  logic          busy;
  logic [15:0]   word_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  bit            hold_valid = 1'b1;
  logic [15:0]   exp_cnt = '0;

  typedef struct {
    logic [DW-1:0] w;
    logic [7:0]    b0;
    logic [7:0]    b1;
    string         name;
  } vec_t;

  always #5 clk = ~clk;

  buffer_uart_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_read     (data_read),
    .tx            (tx),
    .busy          (busy),
    .word_cnt      (word_cnt)
  );

  // Buffer model: presents the head word, pops it after a read pulse.
  always @(negedge clk) begin
    if (data_read === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    data_in_valid = hold_valid || (fifo_q.size() > 0);
    data_in       = (fifo_q.size() > 0) ? fifo_q[0] : DW'(9'h155);
  end

  function automatic logic [7:0] model_b0(input logic [DW-1:0] w);
    return 8'h80 | 8'(w >> 2);
  endfunction

  function automatic logic [7:0] model_b1(input logic [DW-1:0] w);
    return 8'(w & DW'(3));
  endfunction

  task automatic chk(input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", what, act, req);
    end
  endtask

  // Waits for a read pulse, then samples one whole word time on the line.
  task automatic capture(input logic [DW-1:0] w, input logic [7:0] e0, input logic [7:0] e1,
                         input string name, output int waited);
    logic [7:0] b0m, b1m, cur, d0, d1;
    int tx_bad, busy_bad, reads, bitpos, fr, j;
    bit seen, exp_tx;
    b0m = model_b0(w);
    b1m = model_b1(w);
    seen = 1'b0;
    waited = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (data_read === 1'b1) seen = 1'b1;
      else waited++;
    end
    chk({name, " accept"}, int'(seen), 1);
    if (!seen) return;
    tx_bad = 0; busy_bad = 0; reads = 0; d0 = '0; d1 = '0;
    for (int k = 0; k < int'(WORD_CYC); k++) begin
      if (k > 0) @(negedge clk);
      bitpos = k / int'(CPB);
      fr     = bitpos / 10;
      j      = bitpos % 10;
      cur    = (fr != 0) ? b1m : b0m;
      exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j-1];
      if (tx !== exp_tx) tx_bad++;
      if (busy !== 1'(k != int'(WORD_CYC) - 1)) busy_bad++;
      if (data_read === 1'b1) reads++;
      if ((k % int'(CPB)) == int'(CPB) / 2 && j >= 1 && j <= 8) begin
        if (fr == 0) d0[j-1] = tx;
        else         d1[j-1] = tx;
      end
    end
    chk({name, " tx waveform bad cycles"}, tx_bad, 0);
    chk({name, " busy bad cycles"}, busy_bad, 0);
    chk({name, " read pulses"}, reads, 1);
    chk({name, " byte0"}, int'(d0), int'(e0));
    chk({name, " byte1"}, int'(d1), int'(e1));
  endtask

  initial begin
    vec_t          vecs[3];
    int            waited, extra;
    bit            seen;
    logic [DW-1:0] w;

    vecs[0] = '{w: 9'h1A5, b0: 8'hE9, b1: 8'h01, name: "single_1A5"};
    vecs[1] = '{w: 9'h000, b0: 8'h80, b1: 8'h00, name: "zero_000"};
    vecs[2] = '{w: 9'h1FF, b0: 8'hFF, b1: 8'h03, name: "ones_1FF"};

    // Reset held with valid high
    rst = 1'b0;
    hold_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset tx", int'(tx), 1);
      chk("reset data_read", int'(data_read === 1'b1), 0);
      chk("reset busy", int'(busy === 1'b1), 0);
      chk("reset word_cnt", int'(word_cnt), 0);
    end
    hold_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset during bit 3 of byte 0, then a clean restart
    fifo_q.push_back(9'h0AA);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = (data_read === 1'b1);
    end
    chk("middata accept", int'(seen), 1);
    repeat (17) @(negedge clk);
    w = 9'h0AA;
    chk("middata bit3", int'(tx), int'(model_b0(w) >> 3) & 1);
    fifo_q.push_back(9'h0AA);
    rst = 1'b0;
    @(negedge clk);
    chk("middata rst tx", int'(tx), 1);
    chk("middata rst busy", int'(busy === 1'b1), 0);
    chk("middata rst data_read", int'(data_read === 1'b1), 0);
    chk("middata rst word_cnt", int'(word_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    capture(9'h0AA, model_b0(9'h0AA), model_b1(9'h0AA), "restart", waited);
    chk("restart accept delay", waited, 0);
    exp_cnt = exp_cnt + 16'd1;
    chk("restart word_cnt", int'(word_cnt), int'(exp_cnt));

    // Table-driven single words
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(vecs[i].w);
      capture(vecs[i].w, vecs[i].b0, vecs[i].b1, vecs[i].name, waited);
      exp_cnt = exp_cnt + 16'd1;
      chk({vecs[i].name, " word_cnt"}, int'(word_cnt), int'(exp_cnt));
      repeat (3) @(negedge clk);
    end

    // Back-to-back words with valid held high
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h100);
    capture(9'h001, 8'h80, 8'h01, "b2b_first", waited);
    capture(9'h100, 8'hC0, 8'h00, "b2b_second", waited);
    chk("b2b read spacing extra cycles", waited, 0);
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b word_cnt", int'(word_cnt), int'(exp_cnt));
    extra = 0;
    for (int k = 0; k < 3 * int'(CPB); k++) begin
      @(negedge clk);
      if (data_read === 1'b1) extra++;
    end
    chk("b2b extra reads", extra, 0);

    // Random words against the model
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom_range(0, 511));
      fifo_q.push_back(w);
      capture(w, model_b0(w), model_b1(w), "random", waited);
      exp_cnt = exp_cnt + 16'd1;
      chk("random word_cnt", int'(word_cnt), int'(exp_cnt));
    end

    // Counter wrap
    @(negedge clk);
    force dut.word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt;
    @(negedge clk);
    chk("wrap preload", int'(word_cnt), 32'hFFFF);
    fifo_q.push_back(9'h0C3);
    capture(9'h0C3, model_b0(9'h0C3), model_b1(9'h0C3), "wrap", waited);
    chk("wrap word_cnt", int'(word_cnt), 0);
    extra = 0;
    for (int k = 0; k < 2 * int'(CPB); k++) begin
      @(negedge clk);
      if (tx !== 1'b1) extra++;
    end
    chk("wrap idle tx low cycles", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
